// File: rtl/player_input_checker.sv
// Checks a player's debounced key presses against a latched tile sequence.
// Reports pass, fail or timeout with a one-cycle done pulse.
module player_input_checker #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned TIMEOUT_CYCLES  = 150000000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [17:0] seq,
    input  logic [3:0]  length,
    input  logic [3:0]  key_n,
    output logic        busy,
    output logic        press_valid,
    output logic [1:0]  press_tile,
    output logic [3:0]  index,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout
);

    localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StWaitPress, StCheck, StWaitRelease, StPass, StFail
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  key_meta_q, key_sync_q, key_cand_q;
    logic [DebW-1:0] deb_cnt_q;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic        armed_q;
    logic [17:0] seq_q, seq_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  index_q, index_d;
    logic [1:0]  tile_q, tile_d;
    logic        pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;

    logic        deb_ok, all_high_ok;
    logic [3:0]  low_keys;
    logic        one_low, multi_low;
    logic [1:0]  low_tile;
    logic [17:0] seq_shift;
    logic [1:0]  exp_tile;
    logic [3:0]  len_clamped;

    assign deb_ok      = (deb_cnt_q == DebW'(DEBOUNCE_CYCLES));
    assign all_high_ok = deb_ok && (key_cand_q == 4'hF);
    assign low_keys    = ~key_cand_q;
    assign one_low     = (low_keys != 4'h0) && ((low_keys & (low_keys - 4'h1)) == 4'h0);
    assign multi_low   = (low_keys != 4'h0) && !one_low;
    assign seq_shift   = seq_q >> {index_q, 1'b0};
    assign exp_tile    = seq_shift[1:0];
    assign len_clamped = (length > 4'd9) ? 4'd9 : length;

    always_comb begin
        low_tile = 2'd0;
        unique case (low_keys)
            4'b0001: low_tile = 2'd0;
            4'b0010: low_tile = 2'd1;
            4'b0100: low_tile = 2'd2;
            4'b1000: low_tile = 2'd3;
            default: low_tile = 2'd0;
        endcase
    end

    // Synchronizer and debounce; any change in the sampled pattern restarts the count.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            key_meta_q <= 4'hF;
            key_sync_q <= 4'hF;
            key_cand_q <= 4'hF;
            deb_cnt_q  <= '0;
            armed_q    <= 1'b0;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            if (key_sync_q != key_cand_q) begin
                key_cand_q <= key_sync_q;
                deb_cnt_q  <= '0;
            end else if (!deb_ok) begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
            // A key held over from before start must be released before it can count.
            armed_q <= (armed_q && !start) || all_high_ok;
        end
    end

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = '0;
        seq_d     = seq_q;
        len_d     = len_q;
        index_d   = index_q;
        tile_d    = tile_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;

        case (state_q)
            StWaitPress: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (armed_q && deb_ok && one_low) begin
                    state_d = StCheck;
                    tile_d  = low_tile;
                end else if (armed_q && deb_ok && multi_low) begin
                    state_d = StFail;
                    fail_d  = 1'b1;
                end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = StFail;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            StCheck: begin
                if (tile_q != exp_tile) begin
                    state_d = StFail;
                    fail_d  = 1'b1;
                end else if (index_q == len_q - 4'd1) begin
                    state_d = StPass;
                    pass_d  = 1'b1;
                end else begin
                    state_d = StWaitRelease;
                    index_d = index_q + 4'd1;
                end
            end
            StWaitRelease: begin
                if (all_high_ok) state_d = StWaitPress;
            end
            StPass, StFail: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (start) begin
            seq_d     = seq;
            len_d     = len_clamped;
            index_d   = 4'd0;
            to_cnt_d  = '0;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
            pass_d    = (len_clamped == 4'd0);
            state_d   = (len_clamped == 4'd0) ? StPass : StWaitPress;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= StIdle;
            to_cnt_q  <= '0;
            seq_q     <= '0;
            len_q     <= '0;
            index_q   <= '0;
            tile_q    <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            seq_q     <= seq_d;
            len_q     <= len_d;
            index_q   <= index_d;
            tile_q    <= tile_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy        = (state_q == StWaitPress) || (state_q == StCheck) ||
                         (state_q == StWaitRelease);
    assign press_valid = (state_q == StCheck);
    assign done        = (state_q == StPass) || (state_q == StFail);
    assign press_tile  = tile_q;
    assign index       = index_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;

endmodule
